// File: rtl/instr_mem_responder.sv
// Instruction memory responder: synchronous word array behind a
// valid/ready fetch port with programmable response latency.
module instr_mem_responder #(
  parameter int unsigned    MEM_WORDS = 1024,
  parameter logic [31:0]    BASE_ADDR = 32'h8000_0000,
  parameter int unsigned    LATENCY   = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  input  logic [31:0] req_addr_i,
  output logic        req_ready_o,
  output logic        resp_valid_o,
  input  logic        resp_ready_i,
  output logic [31:0] resp_instr_o,
  output logic        resp_error_o,
  input  logic        load_en_i,
  input  logic [31:0] load_addr_i,
  input  logic [31:0] load_data_i,
  output logic [31:0] req_count_o
);

  localparam int unsigned IW = $clog2(MEM_WORDS);
  localparam logic [32:0] Span = 33'(MEM_WORDS) << 2;
  localparam logic [3:0]  LatInit = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_e;

  state_e state_q, state_d;

  logic [31:0] mem_q [MEM_WORDS];

  logic [3:0]  lat_q, lat_d;
  logic [31:0] instr_q, instr_d;
  logic        error_q, error_d;
  logic [31:0] count_q, count_d;

  logic [31:0] req_off, load_off;
  logic        req_ok, load_ok;
  logic        accept, handshake;
  logic [IW-1:0] req_idx, load_idx;

  // Offsets wrap, so addresses below the base fall out of range.
  assign req_off  = req_addr_i - BASE_ADDR;
  assign load_off = load_addr_i - BASE_ADDR;
  assign req_ok   = (req_addr_i[1:0] == 2'b00) &&
                    ({1'b0, req_off} < Span);
  assign load_ok  = (load_addr_i[1:0] == 2'b00) &&
                    ({1'b0, load_off} < Span);
  assign req_idx  = req_off[IW+1:2];
  assign load_idx = load_off[IW+1:2];

  assign accept    = req_valid_i && (state_q == S_IDLE);
  assign handshake = resp_ready_i && (state_q == S_RESP);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      lat_q   <= '0;
      instr_q <= '0;
      error_q <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      lat_q   <= lat_d;
      instr_q <= instr_d;
      error_q <= error_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i && load_en_i && load_ok) begin
      mem_q[load_idx] <= load_data_i;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (req_valid_i) begin
          state_d = (LATENCY > 1) ? S_WAIT : S_RESP;
        end
      end
      S_WAIT: begin
        if (lat_q <= 4'd1) begin
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        if (resp_ready_i) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    lat_d   = lat_q;
    instr_d = instr_q;
    error_d = error_q;
    count_d = count_q;
    if (accept) begin
      lat_d   = LatInit;
      instr_d = req_ok ? mem_q[req_idx] : 32'h0;
      error_d = !req_ok;
    end else if (state_q == S_WAIT && lat_q != 4'd0) begin
      lat_d = lat_q - 4'd1;
    end
    if (handshake) begin
      count_d = count_q + 32'd1;
    end
  end

  always_comb begin
    req_ready_o  = (state_q == S_IDLE);
    resp_valid_o = (state_q == S_RESP);
    resp_instr_o = instr_q;
    resp_error_o = error_q;
    req_count_o  = count_q;
  end

endmodule

// File: tb/tb_instr_mem_responder.sv
// Bench for instr_mem_responder: three latency variants on shared
// inputs, checked against an address-map / word-store reference model.
module tb_instr_mem_responder;

  localparam logic [31:0] BASE = 32'h8000_0000;
  localparam int unsigned WORDS = 1024;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic [31:0] req_addr = '0;
  logic        resp_ready = 1'b0;
  logic        load_en = 1'b0;
  logic [31:0] load_addr = '0;
  logic [31:0] load_data = '0;

  logic        rdy [3];
  logic        rv  [3];
  logic        er  [3];
  logic [31:0] ins [3];
  logic [31:0] cnt [3];

  int lat_m [3] = '{1, 3, 4};
  logic [31:0] cnt_m [3];
  logic [31:0] mem_m [int unsigned];

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  instr_mem_responder #(.MEM_WORDS(WORDS), .BASE_ADDR(BASE), .LATENCY(1)) u_l1 (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_addr_i(req_addr), .req_ready_o(rdy[0]),
    .resp_valid_o(rv[0]), .resp_ready_i(resp_ready),
    .resp_instr_o(ins[0]), .resp_error_o(er[0]),
    .load_en_i(load_en), .load_addr_i(load_addr), .load_data_i(load_data),
    .req_count_o(cnt[0])
  );

  instr_mem_responder #(.MEM_WORDS(WORDS), .BASE_ADDR(BASE), .LATENCY(3)) u_l3 (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_addr_i(req_addr), .req_ready_o(rdy[1]),
    .resp_valid_o(rv[1]), .resp_ready_i(resp_ready),
    .resp_instr_o(ins[1]), .resp_error_o(er[1]),
    .load_en_i(load_en), .load_addr_i(load_addr), .load_data_i(load_data),
    .req_count_o(cnt[1])
  );

  instr_mem_responder #(.MEM_WORDS(WORDS), .BASE_ADDR(BASE), .LATENCY(4)) u_l4 (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_addr_i(req_addr), .req_ready_o(rdy[2]),
    .resp_valid_o(rv[2]), .resp_ready_i(resp_ready),
    .resp_instr_o(ins[2]), .resp_error_o(er[2]),
    .load_en_i(load_en), .load_addr_i(load_addr), .load_data_i(load_data),
    .req_count_o(cnt[2])
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: byte offset from base, word store keyed by word number.
  function automatic void model(input logic [31:0] a,
                                output logic e, output logic [31:0] d);
    longint unsigned off;
    off = longint'(a) - longint'(BASE);
    if (off < 0) off = off + 64'h1_0000_0000;
    if ((a % 4) != 0 || off >= WORDS * 4) begin
      e = 1'b1;
      d = 32'h0;
    end else begin
      e = 1'b0;
      d = mem_m.exists(int'(off / 4)) ? mem_m[int'(off / 4)] : 32'hx;
    end
  endfunction

  function automatic void model_load(input logic [31:0] a, input logic [31:0] d);
    logic e;
    logic [31:0] old;
    model(a, e, old);
    if (!e) mem_m[(a - BASE) / 4] = d;
  endfunction

  task automatic do_load(input logic [31:0] a, input logic [31:0] d);
    load_en = 1'b1;
    load_addr = a;
    load_data = d;
    tick();
    load_en = 1'b0;
    model_load(a, d);
  endtask

  task automatic reset_all();
    rst = 1'b1;
    req_valid = 1'b0;
    resp_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) cnt_m[i] = 32'h0;
  endtask

  task automatic fetch_check(input int s, input logic [31:0] a, input string nm);
    logic e_exp;
    logic [31:0] d_exp;
    int n;
    model(a, e_exp, d_exp);
    req_valid = 1'b1;
    req_addr = a;
    resp_ready = 1'b1;
    n = 0;
    while (rdy[s] !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    tick();
    req_valid = 1'b0;
    n = 1;
    while (rv[s] !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    total++;
    if (n !== lat_m[s]) begin
      bad++;
      $display("FAIL %s latency got=%0d exp=%0d", nm, n, lat_m[s]);
    end
    total++;
    if (ins[s] !== d_exp || er[s] !== e_exp) begin
      bad++;
      $display("FAIL %s data got=%h/%b exp=%h/%b", nm, ins[s], er[s], d_exp, e_exp);
    end
    tick();
    cnt_m[s] = cnt_m[s] + 32'd1;
    total++;
    if (cnt[s] !== cnt_m[s] || rdy[s] !== 1'b1) begin
      bad++;
      $display("FAIL %s count got=%h rdy=%b exp=%h", nm, cnt[s], rdy[s], cnt_m[s]);
    end
  endtask

  task automatic test_reset();
    do_load(BASE + 32'hC, 32'h1234_5678);
    rst = 1'b1;
    load_en = 1'b1;
    load_addr = BASE + 32'hC;
    load_data = 32'hDEAD_BEEF;
    tick();
    load_en = 1'b0;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cnt_m[i] = 32'h0;
      total++;
      if (rdy[i] !== 1'b1 || rv[i] !== 1'b0 || ins[i] !== 32'h0 ||
          er[i] !== 1'b0 || cnt[i] !== 32'h0) begin
        bad++;
        $display("FAIL reset[%0d] got rdy=%b rv=%b ins=%h er=%b cnt=%h exp 1 0 0 0 0",
                 i, rdy[i], rv[i], ins[i], er[i], cnt[i]);
      end
    end
    fetch_check(0, BASE + 32'hC, "reset_load_ignored");
  endtask

  task automatic test_basic();
    reset_all();
    do_load(BASE, 32'h0000_0093);
    fetch_check(0, BASE, "basic");
  endtask

  task automatic test_backpressure();
    int n;
    logic [31:0] held;
    reset_all();
    do_load(BASE + 32'h4, 32'h0010_0113);
    req_valid = 1'b1;
    req_addr = BASE + 32'h4;
    tick();
    req_valid = 1'b0;
    n = 1;
    while (rv[1] !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    total++;
    if (n !== 3 || ins[1] !== 32'h0010_0113) begin
      bad++;
      $display("FAIL bp_first got n=%0d ins=%h exp 3 00100113", n, ins[1]);
    end
    held = ins[1];
    for (int i = 0; i < 5; i++) begin
      tick();
      total++;
      if (rv[1] !== 1'b1 || ins[1] !== 32'h0010_0113 || er[1] !== 1'b0 ||
          rdy[1] !== 1'b0 || cnt[1] !== 32'h0) begin
        bad++;
        $display("FAIL bp_stall%0d got rv=%b ins=%h rdy=%b cnt=%h exp 1 %h 0 0",
                 i, rv[1], ins[1], rdy[1], cnt[1], held);
      end
    end
    resp_ready = 1'b1;
    tick();
    total++;
    if (cnt[1] !== 32'h1 || rv[1] !== 1'b0 || rdy[1] !== 1'b1) begin
      bad++;
      $display("FAIL bp_release got cnt=%h rv=%b rdy=%b exp 1 0 1", cnt[1], rv[1], rdy[1]);
    end
    cnt_m[1] = 32'h1;
  endtask

  task automatic test_faults();
    logic [31:0] addrs [4];
    reset_all();
    do_load(BASE + WORDS * 4 - 4, 32'hCAFE_F00D);
    addrs[0] = BASE + 32'h2;
    addrs[1] = 32'h7FFF_FFFC;
    addrs[2] = BASE + WORDS * 4;
    addrs[3] = BASE + WORDS * 4 - 4;
    for (int i = 0; i < 4; i++) fetch_check(0, addrs[i], $sformatf("fault%0d", i));
  endtask

  task automatic test_collision();
    logic [31:0] a;
    reset_all();
    a = BASE + 32'h8;
    do_load(a, 32'hAAAA_AAAA);
    req_valid = 1'b1;
    req_addr = a;
    resp_ready = 1'b1;
    load_en = 1'b1;
    load_addr = a;
    load_data = 32'h5555_5555;
    tick();
    req_valid = 1'b0;
    load_en = 1'b0;
    total++;
    if (rv[0] !== 1'b1 || ins[0] !== 32'hAAAA_AAAA) begin
      bad++;
      $display("FAIL collide_old got rv=%b ins=%h exp 1 aaaaaaaa", rv[0], ins[0]);
    end
    model_load(a, 32'h5555_5555);
    tick();
    cnt_m[0] = cnt_m[0] + 32'd1;
    fetch_check(0, a, "collide_new");
  endtask

  task automatic test_mid_reset();
    logic [31:0] a;
    reset_all();
    a = BASE + 32'h40;
    do_load(a, 32'h0BAD_C0DE);
    req_valid = 1'b1;
    req_addr = a;
    resp_ready = 1'b1;
    tick();
    req_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      total++;
      if (rv[2] !== 1'b0 || rdy[2] !== 1'b1 || cnt[2] !== 32'h0) begin
        bad++;
        $display("FAIL midrst%0d got rv=%b rdy=%b cnt=%h exp 0 1 0", i, rv[2], rdy[2], cnt[2]);
      end
      tick();
    end
    cnt_m[2] = 32'h0;
    fetch_check(2, a, "midrst_refetch");
  endtask

  task automatic test_stream();
    logic [31:0] a0;
    reset_all();
    a0 = BASE + 32'h200;
    for (int i = 0; i < 100; i++) do_load(a0 + 4 * i, $urandom);
    for (int i = 0; i < 100; i++) fetch_check(0, a0 + 4 * i, $sformatf("stream%0d", i));
    total++;
    if (cnt[0] !== 32'd100) begin
      bad++;
      $display("FAIL stream_count got=%0d exp=100", cnt[0]);
    end
  endtask

  task automatic test_wrap();
    reset_all();
    force u_l1.count_q = 32'hFFFF_FFFF;
    #1;
    release u_l1.count_q;
    #1;
    total++;
    if (cnt[0] !== 32'hFFFF_FFFF) begin
      bad++;
      $display("FAIL wrap_preset got=%h exp=ffffffff", cnt[0]);
    end
    cnt_m[0] = 32'hFFFF_FFFF;
    fetch_check(0, BASE, "wrap");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_faults();
    test_collision();
    test_mid_reset();
    test_stream();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instr_mem_responder.md
# instr_mem_responder

Responder side of the fetch-stage instruction memory interface. It accepts one word-aligned fetch address per request, looks the word up in an internal synchronous instruction array, and returns the instruction after a programmable latency using a valid/ready response handshake. It also has a side-band load port so the bench or boot logic can fill the array. It sits between the fetch step and the rest of the memory system, standing in for the instruction memory.

## Interface
- `MEM_WORDS`, default 1024: depth of the instruction array in 32-bit words; must be a power of two, at least 4.
- `BASE_ADDR`, default 32'h8000_0000: byte address mapped to word 0; must be word-aligned.
- `LATENCY`, default 1: cycles from request acceptance to response valid; legal range 1..15.
- `clk_i`  in  1  single clock; all logic is rising-edge.
- `rst_i`  in  1  reset; synchronous, active-high.
- `req_valid_i`  in  1  fetch request present.
- `req_addr_i`  in  32  fetch byte address.
- `req_ready_o`  out  1  responder can accept a request this cycle.
- `resp_valid_o`  out  1  response data/status valid.
- `resp_ready_i`  in  1  requester consumes the response.
- `resp_instr_o`  out  32  fetched instruction.
- `resp_error_o`  out  1  access fault: misaligned or out-of-range address.
- `load_en_i`  in  1  write one word into the array.
- `load_addr_i`  in  32  load byte address (same mapping as fetch).
- `load_data_i`  in  32  load data.
- `req_count_o`  out  32  number of completed responses; wraps modulo 2^32.

## Operation
- **Address mapping**
  - offset = req_addr_i − BASE_ADDR, computed as 32-bit unsigned with wrap, so addresses below the base become large offsets.
  - The address is in range when offset < MEM_WORDS*4; the word index is offset[31:2].
  - The address is misaligned when addr[1:0] ≠ 0.
  - Misaligned or out-of-range → resp_error_o = 1 and resp_instr_o = 32'h0.
- **State machine** (three states)
  - IDLE: req_ready_o = 1. On req_valid_i && req_ready_o, capture the address, do the array read and error check, load the latency counter with LATENCY−1, then go to WAIT if LATENCY > 1, otherwise to RESP.
  - WAIT: decrement the counter each cycle; go to RESP when it reaches 0.
  - RESP: resp_valid_o = 1. resp_instr_o and resp_error_o are held stable until resp_ready_i = 1. On the handshake edge, increment req_count_o and return to IDLE.
- req_ready_o is 0 in WAIT and RESP. Requests arriving then are not accepted; the requester must hold req_valid_i and req_addr_i until accepted.
- The array is read at the acceptance edge, so response data reflects array contents at acceptance.
- **Load port**
  - Active in every state; writes array[index] = load_data_i on the rising edge.
  - Misaligned or out-of-range loads are silently dropped.
  - A load to the same word on the same edge as acceptance returns the old word (read-before-write).
- The array is not cleared by reset.

## Timing
- Reset values:
  - req_ready_o = 1 (state IDLE).
  - resp_valid_o = 0, resp_instr_o = 0, resp_error_o = 0.
  - req_count_o = 0; latency counter = 0.
- Reset mid-operation (WAIT or RESP): the pending request is discarded, no count increment. The next cycle is IDLE with the reset values above.
- Reset has priority over load: a load on the reset edge is ignored.
- Latency: request accepted at edge t → resp_valid_o high in the cycle after edge t+LATENCY−1.
  - LATENCY = 1 gives a two-cycle fetch: address cycle, then data cycle.
- With resp_ready_i tied high, the minimum request-to-request spacing is LATENCY+1 cycles.
- All outputs are registered; there is no combinational path from any input to any output.

## Test plan
- **Reset and basic fetch.** Reset, load 32'h0000_0093 at 32'h8000_0000, LATENCY = 1. Request 32'h8000_0000 with resp_ready_i = 1.
  - Expect resp_valid_o in the cycle after acceptance, resp_instr_o = 32'h0000_0093, resp_error_o = 0, then req_count_o = 1.
- **Backpressure.** LATENCY = 3; request 32'h8000_0004 holding 32'h0010_0113; keep resp_ready_i = 0 for 5 cycles.
  - Expect resp_valid_o after 3 cycles, data stable throughout the stall, req_ready_o = 0 throughout, and req_count_o increments only on the handshake edge.
- **Faults.**
  - 32'h8000_0002 → error = 1, instr = 0.
  - 32'h7FFF_FFFC → error = 1 (wrapped offset).
  - BASE_ADDR + MEM_WORDS*4 → error = 1.
  - BASE_ADDR + MEM_WORDS*4 − 4 → error = 0.
- **Load/fetch collision.** On the acceptance edge for 32'h8000_0008 (old value 32'hAAAA_AAAA), load 32'h5555_5555 to the same address.
  - Expect the response to be 32'hAAAA_AAAA; a following fetch returns 32'h5555_5555.
- **Reset mid-operation.** Assert rst_i during WAIT with LATENCY = 4.
  - Expect no resp_valid_o, req_ready_o = 1 and req_count_o = 0 after reset, and array contents preserved on a re-fetch.
- **Counter wrap and streaming.** 100 back-to-back fetches of sequential words with resp_ready_i = 1.
  - Expect each response to match the loaded data and req_count_o = 100.
  - Separately, force req_count_o to 32'hFFFF_FFFF; one more response wraps it to 0.
